// File: rtl/prbs_word_generator.sv
// Parallel PRBS7/15/23/31 word source with valid/ready output, restart, word counter and zero-lock guard.
// Optional one-shot bit-0 error injection is compiled in when PRBS_ERR_INJECT_EN is defined.
module prbs_word_generator #(
   parameter int          DATA_W = 8,
   parameter logic [30:0] SEED   = 31'h7FFF_FFFF,
   parameter int          CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic              restart,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  word_count,
   input  logic              inj_req,
   output logic              inj_pending,
   output logic [1:0]        fsm_state
);

   // Handshake: a word transfers on every rising clk edge where out_valid & out_ready are both 1;
   // while out_valid & !out_ready the word, the LFSR and word_count stay frozen.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] word;
      logic [30:0]       state;
   } step_t;

   function automatic logic [30:0] poly_mask(input logic [1:0] m);
      logic [30:0] r;
      case (m)
         2'd0:    r = 31'h0000_007F;
         2'd1:    r = 31'h0000_7FFF;
         2'd2:    r = 31'h007F_FFFF;
         default: r = 31'h7FFF_FFFF;
      endcase
      return r;
   endfunction

   // A seed whose low N bits are all zero would lock the register, so it is replaced by 1.
   function automatic logic [30:0] seed_for(input logic [1:0] m);
      logic [30:0] masked;
      masked = SEED & poly_mask(m);
      return (masked == 31'd0) ? 31'd1 : masked;
   endfunction

   function automatic logic step_bit(input logic [30:0] s, input logic [1:0] m);
      logic b;
      case (m)
         2'd0:    b = s[6]  ^ s[5];
         2'd1:    b = s[14] ^ s[13];
         2'd2:    b = s[22] ^ s[17];
         default: b = s[30] ^ s[27];
      endcase
      return b;
   endfunction

   // DATA_W serial steps unrolled; word bit i is the bit produced by step i.
   function automatic step_t step_word(input logic [30:0] s_in, input logic [1:0] m);
      step_t       r;
      logic [30:0] s;
      logic        b;
      s      = s_in;
      r.word = '0;
      for (int i = 0; i < DATA_W; i++) begin
         b         = step_bit(s, m);
         r.word[i] = b;
         s         = {s[29:0], b};
      end
      r.state = s;
      return r;
   endfunction

   state_t            state;
   logic [1:0]        mode_q;
   logic [30:0]       lfsr;
   logic [DATA_W-1:0] data_q;
   step_t             run_step;
   step_t             load_step;
   logic              accept;
   logic              zero_lock;

   assign run_step  = step_word(lfsr, mode_q);
   assign load_step = step_word(seed_for(mode), mode);
   assign accept    = out_valid & out_ready;
   assign zero_lock = ((lfsr & poly_mask(mode_q)) == 31'd0);
   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mode_q     <= 2'd0;
         lfsr       <= SEED;
         data_q     <= '0;
         out_valid  <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (enable) state <= LOAD;
            end
            // The first word is produced from the seed on the edge that leaves LOAD.
            LOAD: begin
               if (!enable) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end else begin
                  mode_q     <= mode;
                  lfsr       <= load_step.state;
                  data_q     <= load_step.word;
                  word_count <= '0;
                  out_valid  <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (accept) word_count <= word_count + CNT_W'(1);
               if (!enable) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end else if (restart || (mode != mode_q)) begin
                  state     <= LOAD;
                  out_valid <= 1'b0;
               end else if (zero_lock) begin
                  lfsr <= seed_for(mode_q);
                  if (accept) out_valid <= 1'b0;
               end else if (!out_valid || accept) begin
                  data_q    <= run_step.word;
                  lfsr      <= run_step.state;
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef PRBS_ERR_INJECT_EN
   logic inj_q;

   // An accept consumes the armed error; a request on that same edge arms the following word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_q <= 1'b0;
      end else if (accept) begin
         inj_q <= inj_req;
      end else if (inj_req) begin
         inj_q <= 1'b1;
      end
   end

   assign out_data    = data_q ^ {{(DATA_W-1){1'b0}}, inj_q};
   assign inj_pending = inj_q;
`else
   logic unused_inj;
   assign unused_inj  = inj_req;
   assign out_data    = data_q;
   assign inj_pending = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_word_generator.sv
// Directed bench for prbs_word_generator: hand-computed word table, serial golden model,
// random backpressure scoreboard, restart, counter wrap, async reset and error injection.
module tb_prbs_word_generator;

   localparam int DW = 8;
`ifdef PRBS_ERR_INJECT_EN
   localparam logic INJ = 1'b1;
`else
   localparam logic INJ = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [1:0]    mode;
   logic          restart;
   logic          out_ready;
   logic          inj_req;
   logic [DW-1:0] out_data,    out_data4;
   logic          out_valid,   out_valid4;
   logic [31:0]   word_count;
   logic [3:0]    word_count4;
   logic          inj_pending, inj_pending4;
   logic [1:0]    fsm_state,   fsm_state4;

   always #5 clk = ~clk;

   prbs_word_generator #(.DATA_W(DW), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .restart(restart),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .word_count(word_count), .inj_req(inj_req), .inj_pending(inj_pending),
      .fsm_state(fsm_state)
   );

   prbs_word_generator #(.DATA_W(DW), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .restart(restart),
      .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
      .word_count(word_count4), .inj_req(inj_req), .inj_pending(inj_pending4),
      .fsm_state(fsm_state4)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serial golden model
   logic [30:0] m_s;
   logic [1:0]  m_mode;

   function automatic int n_of(input logic [1:0] m);
      case (m)
         2'd0: return 7;
         2'd1: return 15;
         2'd2: return 23;
         default: return 31;
      endcase
   endfunction

   function automatic int t_of(input logic [1:0] m);
      case (m)
         2'd0: return 6;
         2'd1: return 14;
         2'd2: return 18;
         default: return 28;
      endcase
   endfunction

   task automatic model_load(input logic [1:0] m);
      logic [31:0] mask;
      mask   = (32'd1 << n_of(m)) - 32'd1;
      m_mode = m;
      m_s    = 31'h7FFF_FFFF & mask[30:0];
      if (m_s == 31'd0) m_s = 31'd1;
   endtask

   task automatic model_next(output logic [DW-1:0] w);
      int   n;
      int   t;
      logic b;
      n = n_of(m_mode);
      t = t_of(m_mode);
      for (int i = 0; i < DW; i++) begin
         b    = m_s[n-1] ^ m_s[t-1];
         w[i] = b;
         m_s  = {m_s[29:0], b};
      end
   endtask

   // Returns with the first word presented (two edges after enable rises).
   task automatic start(input logic [1:0] m, input string tag);
      enable  = 1'b0;
      restart = 1'b0;
      inj_req = 1'b0;
      tick();
      mode   = m;
      enable = 1'b1;
      tick();
      check({tag, " load valid"}, out_valid, 0);
      tick();
      check({tag, " first valid"}, out_valid, 1);
      model_load(m);
   endtask

   typedef struct {
      logic [1:0] mode;
      int         idx;
      logic [7:0] exp;
   } vec_t;

   vec_t          vecs[7];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] hist[127];
   logic [DW-1:0] w;
   logic [DW-1:0] held;
   logic [DW-1:0] expw;
   logic          stalled;
   int            accepts;

   initial begin
      vecs[0] = '{2'd0, 0, 8'h40};
      vecs[1] = '{2'd0, 1, 8'h30};
      vecs[2] = '{2'd0, 2, 8'h14};
      vecs[3] = '{2'd1, 0, 8'h00};
      vecs[4] = '{2'd1, 1, 8'h40};
      vecs[5] = '{2'd2, 2, 8'h7C};
      vecs[6] = '{2'd3, 3, 8'h70};

      rst = 1'b1; enable = 1'b0; mode = 2'd0; restart = 1'b0;
      out_ready = 1'b0; inj_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset valid", out_valid, 0);
      check("reset data", out_data, 0);
      check("reset count", word_count, 0);
      check("reset pending", inj_pending, 0);
      check("reset state", fsm_state, 0);
      rst = 1'b0;
      tick();

      // Hand-computed words per mode
      for (int v = 0; v < 7; v++) begin
         start(vecs[v].mode, "vec");
         out_ready = 1'b1;
         for (int k = 0; k < vecs[v].idx; k++) tick();
         check("vec word", out_data, vecs[v].exp);
      end

      // Full-throughput stream against the serial model, plus PRBS7 period
      for (int m = 0; m < 4; m++) begin
         start(2'(m), "stream");
         out_ready = 1'b1;
         for (int k = 0; k < 300; k++) begin
            model_next(w);
            check("stream word", out_data, w);
            if (m == 0 && k < 127) hist[k] = w;
            if (m == 0 && k >= 127 && k < 254) check("prbs7 period", out_data, hist[k-127]);
            tick();
         end
         check("stream count", word_count, 300);
         check("stream count4", word_count4, 4'd12);
      end

      // Mode change 1 -> 3 mid-run
      start(2'd1, "mchg");
      out_ready = 1'b1;
      repeat (20) tick();
      mode = 2'd3;
      tick();
      check("mchg load valid", out_valid, 0);
      check("mchg load state", fsm_state, 1);
      tick();
      model_load(2'd3);
      for (int k = 0; k < 4; k++) begin
         model_next(w);
         check("mchg valid", out_valid, 1);
         check("mchg word", out_data, w);
         check("mchg count", word_count, 32'(k));
         tick();
      end

      // Random backpressure with scoreboard
      start(2'd0, "rand");
      for (int k = 0; k < 400; k++) begin
         model_next(w);
         exp_q.push_back(w);
      end
      accepts = 0;
      for (int c = 0; c < 400; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         stalled   = out_valid && !out_ready;
         held      = out_data;
         if (out_valid && out_ready) begin
            expw = exp_q.pop_front();
            check("rand accept", out_data, expw);
            accepts++;
         end
         tick();
         if (stalled) begin
            check("stall data", out_data, held);
            check("stall valid", out_valid, 1);
         end
      end
      out_ready = 1'b0;
      check("rand count", word_count, 32'(accepts));
      check("rand count4", word_count4, 4'(accepts));

      // Restart after 100 words
      start(2'd0, "rst100");
      out_ready = 1'b1;
      repeat (100) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart gap", out_valid, 0);
      tick();
      check("restart valid", out_valid, 1);
      check("restart word", out_data, 8'h40);
      check("restart count", word_count, 0);
      tick();
      check("restart word2", out_data, 8'h30);
      check("restart count2", word_count, 1);

      // 4-bit counter wraps after 16 accepts
      start(2'd0, "wrap");
      out_ready = 1'b1;
      repeat (17) tick();
      check("wrap count4", word_count4, 4'd1);
      check("wrap count32", word_count, 17);

      // Asynchronous reset while a word is stalled
      start(2'd0, "arst");
      out_ready = 1'b1;
      repeat (5) tick();
      out_ready = 1'b0;
      repeat (2) tick();
      check("arst stalled valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst valid", out_valid, 0);
      check("arst data", out_data, 0);
      check("arst count", word_count, 0);
      check("arst state", fsm_state, 0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start(2'd0, "arst");
      check("arst first word", out_data, 8'h40);

      // Error injection on word 5
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         model_next(w);
         inj_req = (k == 4);
         expw    = w;
         expw[0] = w[0] ^ (INJ && (k == 5));
         check("inj word", out_data, expw);
         tick();
         if (k == 4) check("inj armed", inj_pending, INJ);
         if (k == 5) check("inj cleared", inj_pending, 0);
      end
      inj_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
